bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the width of the BRAM read data and of the stream data, in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, is the width of the BRAM word address, in bits.
REQ-003 Parameter LEN_WIDTH, default 16, is the width of the burst length field, in bits.
REQ-004 Port aclk, input, 1 bit, is the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1 bit, is the reset; it SHALL be synchronous and active-high.
REQ-006 Port cmd_addr, input, ADDR_WIDTH bits, is the start word address of the burst.
REQ-007 Port cmd_len, input, LEN_WIDTH bits, is the burst length minus one, so a burst is cmd_len+1 words.
REQ-008 Ports cmd_valid (input, 1 bit) and cmd_ready (output, 1 bit) form the command handshake.
REQ-009 Port bram_addr, output, ADDR_WIDTH bits, is the registered read address driven to the BRAM read port.
REQ-010 Port bram_data, input, DATA_WIDTH bits, is the BRAM read data; it SHALL be valid one aclk edge after the edge that sampled bram_addr.
REQ-011 Ports m_axis_tdata (output, DATA_WIDTH bits), m_axis_tvalid (output, 1 bit), m_axis_tready (input, 1 bit) and m_axis_tlast (output, 1 bit) form the AXI-Stream master.
REQ-012 Port busy, output, 1 bit, SHALL be high from command acceptance until the last beat is transferred.

Function
REQ-013 The FSM SHALL have two states: IDLE and READ.
REQ-014 cmd_ready SHALL equal (state==IDLE); a command is accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-015 On acceptance the block SHALL go IDLE->READ, load bram_addr with cmd_addr, and load its issue and beat counters with cmd_len.
REQ-016 In READ, the block SHALL issue a read (advance bram_addr by 1) only when the reads in flight plus the words buffered total fewer than 2.
REQ-017 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; address all-ones SHALL wrap to 0 within a burst.
REQ-018 Returned data SHALL be captured into a 2-entry output buffer; no word SHALL be dropped, duplicated or reordered under any m_axis_tready pattern.
REQ-019 With m_axis_tready held high, the first m_axis_tvalid SHALL rise 2 cycles after command acceptance, and the block SHALL then sustain 1 beat per cycle.
REQ-020 Once m_axis_tvalid is high, m_axis_tdata and m_axis_tlast SHALL be held stable until the beat is transferred (tvalid and tready both high).
REQ-021 m_axis_tlast SHALL be high only on beat cmd_len+1 of the burst.
REQ-022 The FSM SHALL go READ->IDLE on the edge that transfers the tlast beat; cmd_ready SHALL be high in the next cycle.
REQ-023 cmd_valid SHALL be ignored while in READ; cmd_addr and cmd_len are sampled only at acceptance.
REQ-024 cmd_len = 0 SHALL produce exactly one beat, with tlast high.
REQ-025 cmd_len = all-ones SHALL produce 2^LEN_WIDTH beats with no counter overflow.

Reset
REQ-026 While rst is high at an edge: state SHALL become IDLE; bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast and busy SHALL become 0; all counters and the buffer SHALL be cleared.
REQ-027 A reset asserted during READ SHALL abort the burst; no further beat SHALL be emitted and data still in flight SHALL be discarded.
REQ-028 cmd_ready SHALL be 0 while rst is high and SHALL be 1 in the first cycle after rst is released.

Structure
REQ-029 The state encodings SHALL be local parameters; no shared package is required.
REQ-030 The 2-entry output buffer SHALL be a separate sub-module, axis_skid_buffer, parameterised by DATA_WIDTH, with a 1-bit tlast sideband.
REQ-031 The target size is 150-300 lines of RTL in total.

Verification
REQ-032 Directed scenario, single beat: cmd_addr=0x0010, cmd_len=0, tready=1 -> one beat, tdata=mem[0x10], tlast=1; cmd_ready is high again after that beat.
REQ-033 Directed scenario, streaming burst: cmd_addr=0x0100, cmd_len=3, tready=1 -> 4 consecutive beats mem[0x100..0x103], tlast on the 4th beat, first tvalid 2 cycles after acceptance.
REQ-034 Directed scenario, backpressure: cmd_len=7, tready toggles 1,0,0,1,0,1... -> all 8 words delivered in order, tdata stable while stalled, at most 2 reads outstanding or buffered.
REQ-035 Directed scenario, wrap-around: ADDR_WIDTH=16, cmd_addr=0xFFFE, cmd_len=3 -> beats mem[0xFFFE], mem[0xFFFF], mem[0x0000], mem[0x0001].
REQ-036 Directed scenario, reset mid-burst: rst pulsed for 1 cycle after the 2nd beat of a cmd_len=7 burst -> tvalid=0, busy=0, no further beats; a new cmd_len=1 command then completes normally.
REQ-037 Directed scenario, command while busy: cmd_valid held high with a new cmd_addr during a burst -> it is ignored until IDLE and then accepted exactly once.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared constants and helpers for the BRAM-to-AXI-Stream burst reader.
package bram_stream_reader_pkg;

  // Words the output buffer can hold; also the cap on reads in flight plus words buffered.
  localparam int unsigned BufDepth = 2;

  // One more read may be issued at this edge if the words already committed (in flight plus
  // buffered), less the beat leaving at this same edge, stay under the buffer depth.
  function automatic logic read_credit(input logic       in_flight,
                                       input logic [1:0] buffered,
                                       input logic       pop);
    logic [2:0] used;
    logic [2:0] limit;
    used  = {2'b00, in_flight} + {1'b0, buffered};
    limit = 3'(BufDepth) + {2'b00, pop};
    return used < limit;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream output buffer with a tlast sideband. The upstream side has no ready:
// the producer must never push more words than there are free entries.
module axis_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [1:0]            count
);

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic                  load_out;

  // The output register may only change when it is empty or its beat leaves this edge.
  assign load_out = !out_vld_q || out_ready;

  // Next-state: refill the output from the skid entry first to keep order, else from input.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (load_out) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        skid_vld_d = in_valid;
        if (in_valid) begin
          skid_data_d = in_data;
          skid_last_d = in_last;
        end
      end else begin
        out_vld_d = in_valid;
        if (in_valid) begin
          out_data_d = in_data;
          out_last_d = in_last;
        end
      end
    end else if (in_valid) begin
      skid_vld_d  = 1'b1;
      skid_data_d = in_data;
      skid_last_d = in_last;
    end
  end

  // Buffer registers, cleared by reset.
  always_ff @(posedge aclk) begin
    if (rst) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign count     = {1'b0, out_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of cmd_len+1 consecutive words from a 1-cycle-latency BRAM port and streams
// them out over AXI-Stream, with credit-based read issue so the output buffer never overflows.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy
);

  localparam logic StIdle = 1'b0;
  localparam logic StRead = 1'b1;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  issue_cnt_q;   // reads still to issue, minus one
  logic                  issue_done_q;  // every read of the burst has been issued
  logic [LEN_WIDTH-1:0]  beat_cnt_q;    // beats still to transfer, minus one
  logic                  rd_vld_q;      // bram_data carries a wanted word this cycle
  logic                  rd_last_q;     // ... and it is the final word of the burst
  logic [1:0]            buf_count;
  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  last_pop;

  assign accept   = cmd_valid && cmd_ready;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign last_pop = pop && (beat_cnt_q == '0);
  assign issue    = (state_q == StRead) && !issue_done_q &&
                    read_credit(rd_vld_q, buf_count, pop);

  // State register.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in idle, return to idle as the final beat leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRead;
      StRead: if (last_pop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; cmd_ready is forced low while reset is held.
  always_comb begin
    cmd_ready = !rst && (state_q == StIdle);
    busy      = (state_q == StRead);
  end

  // Read issue, burst counters and the one-stage tracker of data returning from the BRAM.
  always_ff @(posedge aclk) begin
    if (rst) begin
      addr_q       <= '0;
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      beat_cnt_q   <= '0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q       <= cmd_addr;
        issue_cnt_q  <= cmd_len;
        issue_done_q <= 1'b0;
        beat_cnt_q   <= cmd_len;
      end else begin
        if (issue) begin
          // The BRAM samples addr_q at this edge; move on to the next word.
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (issue_cnt_q == '0) begin
            issue_done_q <= 1'b1;
          end else begin
            issue_cnt_q <= issue_cnt_q - LEN_WIDTH'(1);
          end
        end
        if (pop && (beat_cnt_q != '0)) begin
          beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
        end
      end
      rd_vld_q  <= issue;
      rd_last_q <= issue && (issue_cnt_q == '0);
    end
  end

  assign bram_addr = addr_q;

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .aclk     (aclk),
    .rst      (rst),
    .in_valid (rd_vld_q),
    .in_data  (bram_data),
    .in_last  (rd_last_q),
    .out_valid(m_axis_tvalid),
    .out_data (m_axis_tdata),
    .out_last (m_axis_tlast),
    .out_ready(m_axis_tready),
    .count    (buf_count)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a burst-level model predicts every beat,
// handshake and busy flag; directed scenarios also pin exact literal values.
module tb_bram_stream_reader;

  logic        aclk = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len  = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] bram_addr;
  logic [31:0] bram_data = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        busy;

  always #5 aclk = ~aclk;

  bram_stream_reader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .LEN_WIDTH (16)
  ) dut (
    .aclk         (aclk),
    .rst          (rst),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .bram_addr    (bram_addr),
    .bram_data    (bram_data),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'hC3C3, a};
  endfunction

  // BRAM read port: one edge of latency.
  always @(posedge aclk) bram_data <= memf(bram_addr);

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // tready: 0 = always high, 1 = random, 2 = repeating 1,0,0,1,0,1
  int          tr_mode = 0;
  logic [5:0]  pat = 6'b101001;
  logic [2:0]  pidx = '0;
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (tr_mode)
        1: m_axis_tready = 1'($urandom_range(0, 1));
        2: begin
          m_axis_tready = pat[pidx];
          pidx = (pidx == 3'd5) ? 3'd0 : pidx + 3'd1;
        end
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  bit          mon_en = 0;
  bit          m_busy = 0;
  bit          first_pend = 0;
  bit          hold = 0;
  logic [31:0] hold_d;
  logic        hold_l;
  logic [15:0] b_addr = '0;
  int          acc_cyc = 0;
  int          t_cnt = 0;
  int          n_acc = 0;
  int          first_x = 0;
  int          last_x = 0;

  // Model and compare process: checks the cycle's outputs, then advances the model for the
  // coming edge from the current inputs.
  always @(negedge aclk) begin
    if (mon_en) begin
      bit          was_busy;
      beat_t       b;
      logic [15:0] lead;
      was_busy = m_busy;
      check("cmd_ready", 64'(cmd_ready), 64'(!rst && !m_busy));
      check("busy", 64'(busy), 64'(m_busy));
      if (!rst) begin
        if (hold) begin
          check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
          check("stall_tdata", 64'(m_axis_tdata), 64'(hold_d));
          check("stall_tlast", 64'(m_axis_tlast), 64'(hold_l));
        end
        if (m_busy) begin
          // Words fetched ahead of the consumer may never exceed the two-entry budget.
          lead = bram_addr - b_addr - 16'(t_cnt);
          total++;
          if (lead > 16'd2) begin
            bad++;
            $display("FAIL reads_ahead: actual=%0d required<=2 cycle=%0d", lead, cyc);
          end
        end
        if (m_axis_tvalid) begin
          if (exp_q.size() == 0) begin
            check("spurious_beat", 64'(m_axis_tvalid), 64'd0);
          end else begin
            if (first_pend) begin
              check("first_latency", 64'(cyc - acc_cyc), 64'd2);
              first_pend = 0;
            end
            if (m_axis_tready) begin
              b = exp_q.pop_front();
              check("tdata", 64'(m_axis_tdata), 64'(b.data));
              check("tlast", 64'(m_axis_tlast), 64'(b.last));
              obs_q.push_back({m_axis_tdata, m_axis_tlast});
              if (t_cnt == 0) first_x = cyc;
              last_x = cyc;
              t_cnt++;
              if (b.last) m_busy = 0;
            end
          end
        end
        hold   = m_axis_tvalid && !m_axis_tready;
        hold_d = m_axis_tdata;
        hold_l = m_axis_tlast;
      end else begin
        hold = 0;
      end
      if (rst) begin
        exp_q.delete();
        m_busy     = 0;
        first_pend = 0;
      end else if (cmd_valid && !was_busy) begin
        for (int i = 0; i <= int'(cmd_len); i++) begin
          b.data = memf(cmd_addr + 16'(i));
          b.last = (i == int'(cmd_len));
          exp_q.push_back(b);
        end
        m_busy     = 1;
        acc_cyc    = cyc + 1;
        first_pend = 1;
        b_addr     = cmd_addr;
        t_cnt      = 0;
        n_acc++;
      end
    end
  end

  // Present a command and hold it until the handshake edge, then scramble the fields.
  task automatic send(input logic [15:0] a, input logic [15:0] l);
    int k;
    @(posedge aclk);
    #1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    for (k = 0; k < 400; k++) begin
      @(negedge aclk);
      if (cmd_ready) break;
    end
    if (k == 400) begin
      total++;
      bad++;
      $display("FAIL cmd_accept_timeout: actual=not accepted required=accepted cycle=%0d", cyc);
    end
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 16'($urandom);
    cmd_len   = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge aclk);
      if (!m_busy && exp_q.size() == 0) break;
    end
    if (k == budget) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: actual=%0d beats pending required=0 cycle=%0d",
               exp_q.size(), cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished cycle=%0d", cyc);
    $fatal(1);
  end

  logic [31:0] lit4[4];
  int          n0;
  int          k;
  logic [15:0] ra;
  logic [15:0] rl;

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_bram_addr", 64'(bram_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    mon_en = 1;
    @(posedge aclk);
    #1;
    rst = 1'b0;

    // Single beat.
    obs_q.delete();
    send(16'h0010, 16'd0);
    wait_done(50);
    check("single_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) begin
      check("single_data", 64'(obs_q[0].data), 64'h0000_0000_C3D3_0010);
      check("single_last", 64'(obs_q[0].last), 64'd1);
    end
    @(negedge aclk);
    check("single_ready_after", 64'(cmd_ready), 64'd1);

    // Streaming burst: four back-to-back beats.
    obs_q.delete();
    send(16'h0100, 16'd3);
    wait_done(50);
    lit4 = '{32'hC2C3_0100, 32'hC2C2_0101, 32'hC2C1_0102, 32'hC2C0_0103};
    check("stream_count", 64'(obs_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) begin
        check("stream_data", 64'(obs_q[i].data), 64'(lit4[i]));
        check("stream_last", 64'(obs_q[i].last), 64'(i == 3));
      end
    end
    check("stream_back_to_back", 64'(last_x - first_x), 64'd3);

    // Backpressure pattern.
    tr_mode = 2;
    pidx    = '0;
    obs_q.delete();
    send(16'h0200, 16'd7);
    wait_done(200);
    check("bp_count", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_q.size()) check("bp_data", 64'(obs_q[i].data), 64'(memf(16'h0200 + 16'(i))));
    end
    tr_mode = 0;

    // Address wrap within a burst.
    obs_q.delete();
    send(16'hFFFE, 16'd3);
    wait_done(50);
    lit4 = '{32'h3C3D_FFFE, 32'h3C3C_FFFF, 32'hC3C3_0000, 32'hC3C2_0001};
    check("wrap_count", 64'(obs_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) check("wrap_data", 64'(obs_q[i].data), 64'(lit4[i]));
    end

    // Reset pulse in the middle of a burst.
    send(16'h0300, 16'd7);
    for (k = 0; k < 60; k++) begin
      @(negedge aclk);
      if (t_cnt >= 2) break;
    end
    if (k == 60) begin
      total++;
      bad++;
      $display("FAIL midrst_wait: actual=%0d beats required=2 cycle=%0d", t_cnt, cyc);
    end
    @(posedge aclk);
    #1;
    rst = 1'b1;
    @(posedge aclk);
    #1;
    rst = 1'b0;
    @(negedge aclk);
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_tdata", 64'(m_axis_tdata), 64'd0);
    repeat (8) @(negedge aclk);
    obs_q.delete();
    send(16'h0400, 16'd1);
    wait_done(50);
    check("postrst_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("postrst_data1", 64'(obs_q[1].data), 64'h0000_0000_C7C2_0401);
      check("postrst_last1", 64'(obs_q[1].last), 64'd1);
    end

    // Command held during a burst: accepted once, only after idle.
    n0 = n_acc;
    obs_q.delete();
    send(16'h0500, 16'd9);
    send(16'h0600, 16'd2);
    wait_done(200);
    repeat (5) @(negedge aclk);
    check("busy_cmd_accepts", 64'(n_acc - n0), 64'd2);
    check("busy_cmd_count", 64'(obs_q.size()), 64'd13);
    if (obs_q.size() == 13) check("busy_cmd_second", 64'(obs_q[10].data), 64'h0000_0000_C5C3_0600);

    // Randomized bursts under random or full-rate backpressure.
    for (int n = 0; n < 40; n++) begin
      tr_mode = (n % 4 == 0) ? 0 : 1;
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      rl = 16'($urandom_range(0, 24));
      obs_q.delete();
      send(ra, rl);
      wait_done(400);
      check("rand_count", 64'(obs_q.size()), 64'(int'(rl) + 1));
      repeat ($urandom_range(0, 3)) @(posedge aclk);
    end

    // One longer burst with random stalls.
    tr_mode = 1;
    obs_q.delete();
    send(16'hFF80, 16'd199);
    wait_done(2000);
    check("long_count", 64'(obs_q.size()), 64'd200);
    tr_mode = 0;

    repeat (4) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
